cnt_ctrl: RTL

CNT_CTRL -- requirements
Module: cnt_ctrl

---
 rtl/cnt_ctrl_pkg.sv | 21 ++
 rtl/cnt_ctrl_presc_div.sv | 36 +++
 rtl/cnt_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the cnt_ctrl counter/timer block.
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned CNT_W_DEF = 10;
  localparam int unsigned PRE_W_DEF = 8;

  localparam logic ONESHOT  = 1'b0;
  localparam logic PERIODIC = 1'b1;

  function automatic logic is_active(input state_e s);
    return (s == S_RUN) || (s == S_PAUSE);
  endfunction

endpackage

// File: rtl/cnt_ctrl_presc_div.sv
// Prescaler: counts 0..div while enabled and flags the terminal cycle as adv.
module presc_div #(
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] div,
  output logic             adv
);

  logic [PRE_W-1:0] pcnt_q;
  logic [PRE_W-1:0] pcnt_d;

  always_comb begin
    adv    = en && (pcnt_q == div);
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (adv) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = pcnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// Configurable one-shot/periodic counter with prescaler, pause and restart control.
module cnt_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned PRE_W = PRE_W_DEF
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
  input  logic [PRE_W-1:0] presc,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             start_ok;
  logic             p_clr;
  logic             p_en;
  logic             p_adv;

  // Prescaler control is kept separate from the main next-state logic so
  // that adv (a function of en) never feeds back into its own enable.
  always_comb begin
    start_ok = start && (period != '0);
    p_clr    = stop || start_ok;
    p_en     = !stop && !start && is_active(state_q) && !pause;
  end

  presc_div #(
    .PRE_W(PRE_W)
  ) u_presc (
    .clk(sclk),
    .rst(rst),
    .clr(p_clr),
    .en (p_en),
    .div(presc_q),
    .adv(p_adv)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    err_d    = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (start) begin
      if (start_ok) begin
        state_d  = S_RUN;
        cnt_d    = '0;
        period_d = period;
        presc_d  = presc;
        mode_d   = mode;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_RUN, S_PAUSE: begin
          // Leaving PAUSE resumes counting in the same cycle, so a pause held
          // for k cycles delays the next wrap by exactly k cycles.
          if (pause) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
            if (p_adv) begin
              if (cnt_q == period_q - CNT_W'(1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (mode_q == ONESHOT) begin
                  state_d = S_DONE;
                end
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    busy_d = is_active(state_d);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      presc_q  <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    cnt  = cnt_q;
    tick = tick_q;
    busy = busy_q;
    done = done_q;
    err  = err_q;
  end

endmodule
